fir_filter: RTL and testbench

Parameterized direct-form FIR filter for unsigned samples with a runtime-programmable coefficient vector. One new input sample is accepted every clock, and one registered output sample is produced every clock. The block sits in a streaming datapath with no handshake: it is always valid and always ready.

---
 rtl/fir_filter.sv | 53 +++++
 tb/tb_fir_filter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/fir_filter.sv
// Direct-form FIR filter for unsigned samples with a live, unlatched coefficient vector.
// One sample in and one saturated, registered sample out on every clock.
module fir_filter #(
   parameter int unsigned IPL = 4,
   parameter int unsigned CEL = 4,
   parameter int unsigned OPL = 6,
   parameter int unsigned IPD = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IPL-1:0]       X,
   input  logic [CEL*IPD-1:0]   c,
   output logic [OPL-1:0]       Y
);

   localparam int unsigned PRD_W = IPL + CEL;
   localparam int unsigned ACC_W = PRD_W + $clog2(IPD);

   logic [IPL-1:0]   dly [1:IPD-1];
   logic [ACC_W-1:0] acc_c;
   logic [OPL-1:0]   sat_c;

   // Tap 0 uses the live input; the remaining taps use the pre-edge delay line.
   always_comb begin
      acc_c = ACC_W'(PRD_W'(c[0 +: CEL]) * PRD_W'(X));
      for (int k = 1; k < int'(IPD); k++) begin
         acc_c = acc_c + ACC_W'(PRD_W'(c[k*CEL +: CEL]) * PRD_W'(dly[k]));
      end
   end

   // Clamp to full scale instead of wrapping.
   if (ACC_W > OPL) begin : g_sat
      assign sat_c = (|acc_c[ACC_W-1:OPL]) ? '1 : acc_c[OPL-1:0];
   end else begin : g_nosat
      assign sat_c = OPL'(acc_c);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 1; k < int'(IPD); k++) begin
            dly[k] <= '0;
         end
         Y <= '0;
      end else begin
         dly[1] <= X;
         for (int k = 2; k < int'(IPD); k++) begin
            dly[k] <= dly[k-1];
         end
         Y <= sat_c;
      end
   end

endmodule

// File: tb/tb_fir_filter.sv
// Scoreboard bench for fir_filter: the stimulus process queues hand-computed outputs,
// and a monitor compares them against Y one time unit after each rising edge.
module tb_fir_filter;

   localparam int unsigned IPL = 4;
   localparam int unsigned CEL = 4;
   localparam int unsigned OPL = 6;
   localparam int unsigned IPD = 5;

   localparam logic [CEL*IPD-1:0] C_ONES = 20'h11111;
   localparam logic [CEL*IPD-1:0] C_RAMP = 20'h54321;
   localparam logic [CEL*IPD-1:0] C_FULL = 20'hFFFFF;
   localparam logic [CEL*IPD-1:0] C_C0_4 = 20'h11114;
   localparam logic [CEL*IPD-1:0] C_ZERO = 20'h00000;

   typedef struct {
      int          exp;
      int          idx;
      string       tag;
   } sb_item_t;

   logic               clk;
   logic               rst;
   logic [IPL-1:0]     X;
   logic [CEL*IPD-1:0] c;
   logic [OPL-1:0]     Y;

   sb_item_t sb_q[$];
   int       checks = 0;
   int       errors = 0;
   int       n_step = 0;

   fir_filter #(.IPL(IPL), .CEL(CEL), .OPL(OPL), .IPD(IPD)) dut (
      .clk (clk),
      .rst (rst),
      .X   (X),
      .c   (c),
      .Y   (Y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock: drive inputs, wait for the edge, then queue the expected Y.
   task automatic step(input logic r, input int x, input logic [CEL*IPD-1:0] cc,
                       input int exp, input string tag);
      sb_item_t it;
      rst = r;
      X   = IPL'(x);
      c   = cc;
      @(posedge clk);
      it.exp = exp;
      it.idx = n_step;
      it.tag = tag;
      sb_q.push_back(it);
      n_step++;
      @(negedge clk);
   endtask

   // Monitor: output is always valid, so each queued expectation is checked after its edge.
   initial begin
      sb_item_t it;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            checks++;
            if (int'(Y) !== it.exp || $isunknown(Y)) begin
               errors++;
               $display("FAIL %s step %0d: Y got %0d expected %0d", it.tag, it.idx, Y, it.exp);
            end
         end
      end
   end

   initial begin
      int t1_x[11]   = '{3, 4, 10, 11, 13, 14, 7, 2, 15, 7, 6};
      int t1_y[11]   = '{3, 7, 17, 28, 41, 52, 55, 47, 51, 45, 37};
      int t2_y[7]    = '{1, 2, 3, 4, 5, 0, 0};
      int t3_y_hi[7] = '{15, 30, 45, 60, 63, 63, 63};
      int t3_y_lo[5] = '{60, 45, 30, 15, 0};
      int wait_cyc;

      rst = 1'b1;
      X   = '0;
      c   = C_ONES;

      // Moving sum
      step(1'b1, 0, C_ONES, 0, "reset");
      step(1'b1, 0, C_ONES, 0, "reset");
      for (int i = 0; i < 11; i++) step(1'b0, t1_x[i], C_ONES, t1_y[i], "moving_sum");

      // Impulse response
      step(1'b1, 0, C_RAMP, 0, "reset");
      for (int i = 0; i < 7; i++) step(1'b0, (i == 0) ? 1 : 0, C_RAMP, t2_y[i], "impulse");

      // Saturation ramp up and decay
      step(1'b1, 0, C_ONES, 0, "reset");
      for (int i = 0; i < 7; i++) step(1'b0, 15, C_ONES, t3_y_hi[i], "sat_hold");
      for (int i = 0; i < 5; i++) step(1'b0, 0, C_ONES, t3_y_lo[i], "sat_decay");

      // Full-scale saturation
      step(1'b1, 0, C_FULL, 0, "reset");
      for (int i = 0; i < 6; i++) step(1'b0, 15, C_FULL, 63, "full_scale");

      // Mid-stream reset
      step(1'b1, 0, C_ONES, 0, "reset");
      for (int i = 0; i < 3; i++) step(1'b0, 10, C_ONES, 10 * (i + 1), "pre_reset");
      step(1'b1, 10, C_ONES, 0, "mid_reset");
      for (int i = 0; i < 3; i++) step(1'b0, 2, C_ONES, 2 * (i + 1), "post_reset");

      // Live coefficient change
      step(1'b1, 0, C_ONES, 0, "reset");
      for (int i = 0; i < 5; i++) step(1'b0, 3, C_ONES, 3 * (i + 1), "steady");
      step(1'b0, 3, C_C0_4, 24, "coef_change");
      step(1'b0, 3, C_ONES, 15, "coef_restore");

      // All-zero coefficients with live history
      step(1'b0, 9, C_ZERO, 0, "zero_coef");
      step(1'b0, 15, C_ZERO, 0, "zero_coef");
      step(1'b0, 1, C_ONES, 3 + 3 + 9 + 15 + 1, "after_zero");

      wait_cyc = 0;
      while (sb_q.size() > 0 && wait_cyc < 10) begin
         @(negedge clk);
         wait_cyc++;
      end
      if (sb_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d entries left expected 0", sb_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
